// File: rtl/mesh_term_injector.sv
// Terminal-side injector: formats host transactions into mesh packets, screens
// out-of-range destinations and buffers legal packets in a show-ahead FIFO.
module mesh_term_injector #(
    parameter int          ROWS       = 4,
    parameter int          COLUMNS    = 4,
    parameter int          PCKG_SZ    = 32,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [7:0]  BDCST      = 8'hFF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [3:0]                           in_row,
    input  logic [3:0]                           in_col,
    input  logic                                 in_mode,
    input  logic [PCKG_SZ-18:0]                  in_payload,
    output logic                                 pndng,
    output logic [PCKG_SZ-1:0]                   data_out,
    input  logic                                 popin,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
    output logic [15:0]                          sent_cnt,
    output logic [15:0]                          drop_cnt,
    output logic                                 err_drop,
    output logic                                 err_underflow
);

    localparam int             CW      = $clog2(FIFO_DEPTH + 1);
    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [3:0]     ROWS_C  = 4'(ROWS);
    localparam logic [3:0]     COLS_C  = 4'(COLUMNS);
    localparam logic [15:0]    SAT_C   = 16'hFFFF;

    logic [PCKG_SZ-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PCKG_SZ-1:0] data_out_q, data_out_d;
    logic [15:0]        sent_q, sent_d;
    logic [15:0]        drop_q, drop_d;
    logic               err_drop_q, err_uf_q;

    logic [PCKG_SZ-1:0] pkt;
    logic [PCKG_SZ-1:0] head;
    logic               legal, accept, push, drop, pop, underflow;

    assign in_ready = !reset && (count_q != DEPTH_C);

    always_comb begin
        pkt       = {8'h00, in_row, in_col, in_mode, in_payload};
        legal     = ((in_row != 4'd0) && (in_row <= ROWS_C) &&
                     (in_col != 4'd0) && (in_col <= COLS_C)) ||
                    ({in_row, in_col} == BDCST);
        accept    = in_valid && in_ready;
        push      = accept && legal;
        drop      = accept && !legal;
        pop       = popin && (count_q != '0);
        underflow = popin && (count_q == '0);

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // The new tail is also the new head only when it lands in an otherwise empty FIFO.
        head       = (push && (wr_ptr_q == rd_ptr_d)) ? pkt : mem_q[rd_ptr_d];
        data_out_d = (count_d != '0) ? head : data_out_q;

        sent_d = (pop  && (sent_q != SAT_C)) ? sent_q + 16'd1 : sent_q;
        drop_d = (drop && (drop_q != SAT_C)) ? drop_q + 16'd1 : drop_q;
    end

    // NOTE: the packet storage has no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pkt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            sent_q     <= '0;
            drop_q     <= '0;
            err_drop_q <= 1'b0;
            err_uf_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            sent_q     <= sent_d;
            drop_q     <= drop_d;
            err_drop_q <= drop;
            err_uf_q   <= underflow;
        end
    end

    assign pndng         = (count_q != '0);
    assign data_out      = data_out_q;
    assign count         = count_q;
    assign sent_cnt      = sent_q;
    assign drop_cnt      = drop_q;
    assign err_drop      = err_drop_q;
    assign err_underflow = err_uf_q;

endmodule

// File: tb/tb_mesh_term_injector.sv
// Directed-plus-random bench for mesh_term_injector against a queue-based packet model.
module tb_mesh_term_injector;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_row;
    logic [3:0]  in_col;
    logic        in_mode;
    logic [14:0] in_payload;
    logic        pndng;
    logic [31:0] data_out;
    logic        popin;
    logic [4:0]  count;
    logic [15:0] sent_cnt;
    logic [15:0] drop_cnt;
    logic        err_drop;
    logic        err_underflow;

    mesh_term_injector dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_row        (in_row),
        .in_col        (in_col),
        .in_mode       (in_mode),
        .in_payload    (in_payload),
        .pndng         (pndng),
        .data_out      (data_out),
        .popin         (popin),
        .count         (count),
        .sent_cnt      (sent_cnt),
        .drop_cnt      (drop_cnt),
        .err_drop      (err_drop),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    string       phase   = "init";

    logic [31:0] q[$];
    logic [31:0] last_data;
    int          m_sent, m_drop;
    bit          m_err_drop, m_err_uf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("pndng",     32'(pndng),         32'(q.size() != 0));
        check("data_out",  data_out,           last_data);
        check("count",     32'(count),         32'(q.size()));
        check("sent_cnt",  32'(sent_cnt),      32'(m_sent));
        check("drop_cnt",  32'(drop_cnt),      32'(m_drop));
        check("err_drop",  32'(err_drop),      32'(m_err_drop));
        check("err_uf",    32'(err_underflow), 32'(m_err_uf));
    endtask

    function automatic logic [31:0] fmt(input logic [3:0] r, input logic [3:0] c,
                                        input bit m, input logic [14:0] p);
        return 32'(r) * 32'h10_0000 + 32'(c) * 32'h1_0000 + 32'(m) * 32'h8000 + 32'(p);
    endfunction

    function automatic bit is_legal(input logic [3:0] r, input logic [3:0] c);
        return (r >= 1 && r <= 4 && c >= 1 && c <= 4) || (r == 15 && c == 15);
    endfunction

    // One clock of stimulus; the model decides from the pre-edge state and is checked after the edge.
    task automatic step(input bit v, input logic [3:0] r, input logic [3:0] c,
                        input bit m, input logic [14:0] p, input bit pop_i);
        int  pre;
        bit  acc, do_push, do_drop, do_pop;
        @(negedge clk);
        reset      = 1'b0;
        in_valid   = v;
        in_row     = r;
        in_col     = c;
        in_mode    = m;
        in_payload = p;
        popin      = pop_i;
        #1;
        pre = q.size();
        check("in_ready", 32'(in_ready), 32'(pre < 16));
        acc     = v && (pre < 16);
        do_push = acc && is_legal(r, c);
        do_drop = acc && !is_legal(r, c);
        do_pop  = pop_i && (pre > 0);
        m_err_uf   = pop_i && (pre == 0);
        m_err_drop = do_drop;
        @(posedge clk);
        if (do_pop) begin
            void'(q.pop_front());
            if (m_sent < 65535) m_sent++;
        end
        if (do_push) q.push_back(fmt(r, c, m, p));
        if (do_drop && m_drop < 65535) m_drop++;
        if (q.size() != 0) last_data = q[0];
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        popin    = 1'b0;
        #1;
        check("in_ready_rst", 32'(in_ready), 32'd0);
        @(posedge clk);
        q.delete();
        last_data  = '0;
        m_sent     = 0;
        m_drop     = 0;
        m_err_drop = 1'b0;
        m_err_uf   = 1'b0;
        #1;
        check_all();
    endtask

    task automatic push_legal(input bit pop_i);
        step(1'b1, 4'($urandom_range(1, 4)), 4'($urandom_range(1, 4)),
             1'($urandom), 15'($urandom), pop_i);
    endtask

    task automatic idle(input bit pop_i);
        step(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 15'($urandom), pop_i);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1'b1);
        check("drained", 32'(count), 32'd0);
    endtask

    initial begin
        int sent0;
        reset = 1'b1; in_valid = 1'b0; popin = 1'b0;
        in_row = '0; in_col = '0; in_mode = 1'b0; in_payload = '0;

        phase = "reset";
        do_reset();

        phase = "single";
        step(1'b1, 4'd2, 4'd3, 1'b0, 15'h1234, 1'b0);
        check("single_pkt", data_out, 32'h0023_1234);
        idle(1'b1);
        check("single_sent", 32'(sent_cnt), 32'd1);
        check("single_empty", 32'(pndng), 32'd0);

        phase = "fill";
        for (int i = 0; i < 17; i++) push_legal(1'b0);
        check("fill_count", 32'(count), 32'd16);
        check("fill_ready", 32'(in_ready), 32'd0);
        idle(1'b1);
        check("fill_ready_after_pop", 32'(in_ready), 32'd1);
        drain();

        phase = "range";
        step(1'b1, 4'd0, 4'd1, 1'b0, 15'h0001, 1'b0);
        step(1'b1, 4'd5, 4'd1, 1'b1, 15'h0002, 1'b0);
        step(1'b1, 4'd1, 4'd9, 1'b0, 15'h0003, 1'b0);
        idle(1'b0);
        check("range_drop", 32'(drop_cnt), 32'd3);
        check("range_count", 32'(count), 32'd0);
        step(1'b1, 4'hF, 4'hF, 1'b1, 15'h7ABC, 1'b0);
        check("bdcst_pkt", data_out, 32'h00FF_FABC);
        drain();

        phase = "pushpop";
        for (int i = 0; i < 4; i++) push_legal(1'b0);
        sent0 = m_sent;
        for (int i = 0; i < 20; i++) push_legal(1'b1);
        check("pp_count", 32'(count), 32'd4);
        check("pp_sent", 32'(sent_cnt), 32'(sent0 + 20));
        drain();

        phase = "underflow";
        idle(1'b1);
        idle(1'b0);
        step(1'b1, 4'd4, 4'd4, 1'b1, 15'h0555, 1'b1);
        check("uf_pushpop_count", 32'(count), 32'd1);
        drain();

        phase = "midreset";
        for (int i = 0; i < 7; i++) push_legal(1'b0);
        check("mr_count7", 32'(count), 32'd7);
        do_reset();
        idle(1'b0);
        step(1'b1, 4'd3, 4'd1, 1'b1, 15'h2222, 1'b0);
        check("mr_count", 32'(count), 32'd1);
        check("mr_head", data_out, 32'h0031_A222);
        drain();

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r, c;
            r = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(1, 4));
            c = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(1, 4));
            step(1'($urandom_range(0, 2) != 0), r, c, 1'($urandom), 15'($urandom),
                 1'($urandom_range(0, 2) == 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
